// File: rtl/pfixed_to_pfloat_v.sv
// Signed two's-complement fixed point to IEEE-754 single precision converter.
// The operand is captured on a Begin/ACK handshake, made positive, normalised
// by one left shift per clock, and packed with a truncated mantissa.
module pfixed_to_pfloat_v #(
    parameter int unsigned FRAC_BITS = 21
) (
    input  logic        CLK,
    input  logic        RST_FX,
    input  logic        RST_FSM_FX,
    input  logic        Begin_FSM_FX,
    input  logic [31:0] FIXED,
    output logic        BUSY_FX,
    output logic        ACK_FX,
    output logic [31:0] RESULT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_NORM,
        S_PACK,
        S_DONE
    } state_t;

    // Biased exponent of an operand whose leading one sits at bit 31:
    // 127 + (31 - FRAC_BITS). The 8-bit subtraction below wraps exactly like
    // a wider sum truncated to 8 bits would.
    localparam logic [7:0] EXP_BASE = 8'(158 - FRAC_BITS);

    state_t      state_q, state_d;
    logic [31:0] fx_q, fx_d;
    logic [31:0] mag_q, mag_d;
    logic        sgn_q, sgn_d;
    logic [4:0]  shcnt_q, shcnt_d;
    logic [31:0] result_q, result_d;
    logic [7:0]  exp_w;

    // Exponent of the normalised magnitude.
    always_comb begin
        exp_w = EXP_BASE - {3'b000, shcnt_q};
    end

    // Next-state and datapath update for the conversion sequence.
    always_comb begin
        state_d  = state_q;
        fx_d     = fx_q;
        mag_d    = mag_q;
        sgn_d    = sgn_q;
        shcnt_d  = shcnt_q;
        result_d = result_q;

        if (RST_FSM_FX) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (Begin_FSM_FX) begin
                        fx_d    = FIXED;
                        shcnt_d = '0;
                        state_d = S_ABS;
                    end
                end
                S_ABS: begin
                    sgn_d   = fx_q[31];
                    mag_d   = fx_q[31] ? (~fx_q + 32'd1) : fx_q;
                    state_d = (fx_q == '0) ? S_PACK : S_NORM;
                end
                S_NORM: begin
                    if (!mag_q[31]) begin
                        mag_d   = mag_q << 1;
                        shcnt_d = shcnt_q + 5'd1;
                    end else begin
                        state_d = S_PACK;
                    end
                end
                S_PACK: begin
                    // Only a zero operand reaches PACK with a zero magnitude.
                    if (mag_q == '0) begin
                        result_d = '0;
                    end else begin
                        result_d = {sgn_q, exp_w, mag_q[30:8]};
                    end
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge CLK or negedge RST_FX) begin
        if (!RST_FX) begin
            state_q  <= S_IDLE;
            fx_q     <= '0;
            mag_q    <= '0;
            sgn_q    <= 1'b0;
            shcnt_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            fx_q     <= fx_d;
            mag_q    <= mag_d;
            sgn_q    <= sgn_d;
            shcnt_q  <= shcnt_d;
            result_q <= result_d;
        end
    end

    // Moore handshake outputs decoded from the registered state.
    always_comb begin
        BUSY_FX = (state_q == S_ABS) || (state_q == S_NORM) || (state_q == S_PACK);
        ACK_FX  = (state_q == S_DONE);
        RESULT  = result_q;
    end

endmodule

// File: tb/tb_pfixed_to_pfloat_v.sv
// Self-checking bench for pfixed_to_pfloat_v with FRAC_BITS = 21.
module tb_pfixed_to_pfloat_v;

    localparam int FB = 21;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic        CLK = 1'b0;
    logic        RST_FX = 1'b0;
    logic        RST_FSM_FX = 1'b0;
    logic        Begin_FSM_FX = 1'b0;
    logic [31:0] FIXED = '0;
    logic        BUSY_FX;
    logic        ACK_FX;
    logic [31:0] RESULT;

    int checks = 0;
    int failures = 0;
    bit finished = 1'b0;

    pfixed_to_pfloat_v #(.FRAC_BITS(FB)) dut (
        .CLK(CLK),
        .RST_FX(RST_FX),
        .RST_FSM_FX(RST_FSM_FX),
        .Begin_FSM_FX(Begin_FSM_FX),
        .FIXED(FIXED),
        .BUSY_FX(BUSY_FX),
        .ACK_FX(ACK_FX),
        .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Real value FIXED / 2^FB, truncated toward zero into single precision.
    function automatic logic [31:0] m_conv(input logic [31:0] v);
        longint     x;
        logic [63:0] a;
        logic [63:0] man;
        int         p;
        logic       s;
        x = longint'(signed'(v));
        s = (x < 0);
        a = s ? 64'(-x) : 64'(x);
        if (a == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 32; i++) if (a >= (64'd1 << i)) p = i;
        man = ((a - (64'd1 << p)) << 23) >> p;
        return {s, 8'(127 + p - FB), man[22:0]};
    endfunction

    function automatic int m_lat(input logic [31:0] v);
        longint x;
        longint a;
        int     p;
        x = longint'(signed'(v));
        a = (x < 0) ? -x : x;
        if (a == 0) return 2;
        p = 0;
        for (int i = 0; i < 32; i++) if (a >= (longint'(1) << i)) p = i;
        return 3 + (31 - p);
    endfunction

    // Reference of the externally visible behaviour: idle / running / done.
    int          m_mode = M_IDLE;
    int          m_left = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_pend = '0;

    always @(posedge CLK or negedge RST_FX) begin
        if (!RST_FX) begin
            m_mode <= M_IDLE;
            m_res  <= '0;
        end else if (RST_FSM_FX) begin
            m_mode <= M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (Begin_FSM_FX) begin
                    m_mode <= M_RUN;
                    m_left <= m_lat(FIXED);
                    m_pend <= m_conv(FIXED);
                end
                M_RUN: begin
                    if (m_left == 1) begin
                        m_mode <= M_DONE;
                        m_res  <= m_pend;
                    end else begin
                        m_left <= m_left - 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison of the DUT against the reference.
    always @(negedge CLK) begin
        if (RST_FX && !finished) begin
            chk("cyc_busy", {31'b0, BUSY_FX}, {31'b0, m_mode == M_RUN});
            chk("cyc_ack", {31'b0, ACK_FX}, {31'b0, m_mode == M_DONE});
            chk("cyc_result", RESULT, m_res);
        end
    end

    // Start a conversion (called away from the rising edge) and measure latency.
    task automatic convert(input logic [31:0] v, output int lat);
        FIXED = v;
        Begin_FSM_FX = 1'b1;
        @(posedge CLK);
        #1 Begin_FSM_FX = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (ACK_FX) break;
        end
    endtask

    task automatic release_done();
        RST_FSM_FX = 1'b1;
        @(posedge CLK);
        #1 RST_FSM_FX = 1'b0;
    endtask

    typedef struct {
        logic [31:0] v;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[7] = '{
        '{32'h00200000, 32'h3F800000, 13},
        '{32'hFFE00000, 32'hBF800000, 13},
        '{32'hFFB00000, 32'hC0200000, 12},
        '{32'h00000000, 32'h00000000, 2},
        '{32'h80000000, 32'hC4800000, 3},
        '{32'h7FFFFFFF, 32'h447FFFFF, 4},
        '{32'h00000001, 32'h35000000, 34}
    };

    initial begin
        int lat;
        logic [31:0] v;

        // Pin the reference model to hand-computed values.
        for (int i = 0; i < 7; i++) begin
            chk("model_conv", m_conv(vecs[i].v), vecs[i].r);
            chk("model_lat", 32'(m_lat(vecs[i].v)), 32'(vecs[i].lat));
        end

        // Power-on reset.
        repeat (2) @(negedge CLK);
        chk("rst_busy", {31'b0, BUSY_FX}, 32'h0);
        chk("rst_ack", {31'b0, ACK_FX}, 32'h0);
        chk("rst_result", RESULT, 32'h0);
        @(posedge CLK);
        #1 RST_FX = 1'b1;
        @(posedge CLK);
        #1;

        // Directed operands.
        for (int i = 0; i < 7; i++) begin
            convert(vecs[i].v, lat);
            chk("dir_ack", {31'b0, ACK_FX}, 32'h1);
            chk("dir_lat", 32'(lat), 32'(vecs[i].lat));
            chk("dir_result", RESULT, vecs[i].r);
            release_done();
        end

        // Begin pulses while busy and while done are ignored.
        FIXED = 32'h00000001;
        Begin_FSM_FX = 1'b1;
        @(posedge CLK);
        #1 Begin_FSM_FX = 1'b0;
        repeat (3) @(posedge CLK);
        #1 Begin_FSM_FX = 1'b1;
        FIXED = 32'h00200000;
        @(posedge CLK);
        #1 Begin_FSM_FX = 1'b0;
        lat = 4;
        while (lat < 60) begin
            @(negedge CLK);
            if (ACK_FX) break;
            @(posedge CLK);
            lat++;
        end
        chk("busy_pulse_lat", 32'(lat), 32'd34);
        chk("busy_pulse_result", RESULT, 32'h35000000);
        Begin_FSM_FX = 1'b1;
        FIXED = 32'h7FFFFFFF;
        @(posedge CLK);
        #1 Begin_FSM_FX = 1'b0;
        @(negedge CLK);
        chk("done_pulse_ack", {31'b0, ACK_FX}, 32'h1);
        chk("done_pulse_result", RESULT, 32'h35000000);

        // FSM reset from DONE keeps RESULT.
        release_done();
        @(negedge CLK);
        chk("fsmrst_ack", {31'b0, ACK_FX}, 32'h0);
        chk("fsmrst_busy", {31'b0, BUSY_FX}, 32'h0);
        chk("fsmrst_result", RESULT, 32'h35000000);

        // FSM reset wins over Begin in IDLE.
        RST_FSM_FX = 1'b1;
        Begin_FSM_FX = 1'b1;
        FIXED = 32'h00200000;
        @(posedge CLK);
        #1 RST_FSM_FX = 1'b0;
        Begin_FSM_FX = 1'b0;
        @(negedge CLK);
        chk("prio_busy", {31'b0, BUSY_FX}, 32'h0);
        @(negedge CLK);
        chk("prio_busy2", {31'b0, BUSY_FX}, 32'h0);
        chk("prio_ack", {31'b0, ACK_FX}, 32'h0);

        // Asynchronous reset in the middle of normalisation.
        @(posedge CLK);
        #1 FIXED = 32'h00000001;
        Begin_FSM_FX = 1'b1;
        @(posedge CLK);
        #1 Begin_FSM_FX = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        #1 RST_FX = 1'b0;
        #1;
        chk("async_busy", {31'b0, BUSY_FX}, 32'h0);
        chk("async_ack", {31'b0, ACK_FX}, 32'h0);
        chk("async_result", RESULT, 32'h0);
        @(posedge CLK);
        #1 RST_FX = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            chk("async_idle_busy", {31'b0, BUSY_FX}, 32'h0);
            chk("async_idle_ack", {31'b0, ACK_FX}, 32'h0);
        end
        @(posedge CLK);
        #1;

        // Randomised sweep against the reference.
        for (int i = 0; i < 10000; i++) begin
            v = $urandom;
            if ($urandom_range(0, 24) == 0) v = v >> $urandom_range(0, 31);
            if ($urandom_range(0, 199) == 0) v = 32'h0;
            convert(v, lat);
            chk("rnd_lat", 32'(lat), 32'(m_lat(v)));
            chk("rnd_result", RESULT, m_conv(v));
            release_done();
        end

        finished = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
